quad_step_decoder: RTL and testbench
====================================

// Module: quad_step_decoder
// PURPOSE
//   Front end for the up/down counter. Takes raw, asynchronous quadrature encoder
//   inputs A/B and synchronises and de-glitches them. Decodes Gray-code steps into
//   single-cycle inc/dec pulses that drive the counter's inc/dec ports directly.
//   Flags illegal transitions (both channels changing at once).
// PARAMETERS
//   SYNC_STAGES  2  synchroniser flops per channel; legal range >= 2
//   FILT_LEN     4  consecutive cycles a new synced level must hold before acceptance; >= 1
//   MODE         0  0 = x4 decode (every edge); 1 = x1 decode (one pulse per full cycle)
// PORTS
//   clk        in   1  clock
//   rst_n      in   1  reset, asynchronous, active-low
//   en         in   1  1 = pulse outputs enabled; 0 = track state only, no pulses
//   a_in       in   1  raw encoder channel A, asynchronous to clk
//   b_in       in   1  raw encoder channel B, asynchronous to clk
//   clr_err    in   1  synchronous clear of err_sticky
//   inc        out  1  one-cycle pulse per forward step
//   dec        out  1  one-cycle pulse per reverse step
//   err        out  1  one-cycle pulse on an illegal transition
//   err_sticky out  1  set by err; held until clr_err or reset
// BEHAVIOUR
//   Reset (async assert, sync-released by clk):
//   - All sync flops, filtered levels, prev state, filter counters, inc, dec, err and
//     err_sticky go to 0.
//   - FSM goes to INIT.
//   Sync:
//   - Each channel passes through SYNC_STAGES flops.
//   Filter (per channel, counter width $clog2(FILT_LEN+1)):
//   - Counter increments each cycle the synced level != the filtered level.
//   - Counter clears when they are equal.
//   - The filtered level takes the synced level on the edge where the counter
//     reaches FILT_LEN; the counter clears on that same edge.
//   - Glitches shorter than FILT_LEN cycles are never seen downstream.
//   FSM:
//   - INIT: a counter runs SYNC_STAGES+FILT_LEN+1 cycles after reset release.
//     prev={a_f,b_f} is loaded every cycle. inc/dec/err are held 0. Then go to RUN.
//   - RUN: cur={a_f,b_f} is compared with prev every cycle, then prev<=cur.
//   - No transition back to INIT except by reset.
//   Decode (RUN, registered outputs, asserted the cycle after cur changes):
//   - Forward sequence is 00->01->11->10->00; reverse is its inverse.
//   - MODE 0: forward step -> inc=1; reverse step -> dec=1.
//   - MODE 1: inc only on 10->00; dec only on 00->10; other legal steps give no pulse.
//   - Both bits changed (00<->11, 01<->10): err=1, no inc/dec.
//     prev is resynchronised to cur. err_sticky<=1.
//   - cur==prev: all pulses 0.
//   Rules and timing:
//   - inc and dec are never high in the same cycle.
//   - At most one pulse per cycle; pulses are exactly 1 cycle wide.
//   - Latency: a_in toggling and held stable gives an inc/dec pulse exactly
//     SYNC_STAGES+FILT_LEN+1 cycles after the first clk edge that samples the new
//     level (7 with defaults).
//   - Minimum step spacing is FILT_LEN+1 cycles; closer edges are absorbed by the filter.
//   - en=0: prev keeps tracking; inc/dec/err are forced 0 and err_sticky is not set.
//     Re-asserting en never emits a pulse for motion that occurred while disabled.
//   - clr_err and err in the same cycle: set wins, err_sticky=1.
//   - Reset mid-operation: outputs drop to 0 immediately and asynchronously.
//     After release the block re-enters INIT. There is no error and no pulse for the
//     encoder position at release, even if it is 11.
// TESTING
//   1. Reset release with A/B=11 held -> no inc/dec/err during or after INIT;
//      err_sticky=0.
//   2. MODE0: after INIT, drive 00->01->11->10->00 with 20-cycle spacing ->
//      4 inc pulses, each 7 cycles after its edge; dec=0.
//   3. MODE0: reverse sequence 00->10->11->01->00 -> 4 dec pulses.
//      With MODE1, the same stimulus gives 1 dec pulse (on 00->10) and no inc.
//   4. 3-cycle glitch on A (FILT_LEN=4) -> no pulse.
//      5-cycle pulse on A -> inc then dec, each 1 cycle wide.
//   5. A and B toggle together 00->11 -> err=1 for 1 cycle, err_sticky=1, no inc/dec.
//      clr_err -> err_sticky=0.
//   6. en=0 while stepping 3 forward, then en=1 -> no pulses.
//      The next forward step gives exactly 1 inc.
//      rst_n pulsed mid-step -> outputs 0 the same cycle.

Source files
------------

// File: rtl/quad_step_decoder_if.sv
// Encoder-side and counter-side signals of the quadrature step decoder.
// The master drives the raw encoder and control inputs; the slave is the decoder.
interface quad_step_decoder_if;
  logic en;
  logic a_in;
  logic b_in;
  logic clr_err;
  logic inc;
  logic dec;
  logic err;
  logic err_sticky;

  modport master (
    output en,
    output a_in,
    output b_in,
    output clr_err,
    input  inc,
    input  dec,
    input  err,
    input  err_sticky
  );

  modport slave (
    input  en,
    input  a_in,
    input  b_in,
    input  clr_err,
    output inc,
    output dec,
    output err,
    output err_sticky
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronise and de-glitch raw A/B, then decode Gray-code
// steps into single-cycle inc/dec pulses and flag illegal double-channel jumps.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int MODE        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  quad_step_decoder_if.slave bus
);

  localparam int CNT_W    = $clog2(FILT_LEN + 1);
  localparam int INIT_CYC = SYNC_STAGES + FILT_LEN + 1;
  localparam int INIT_W   = $clog2(INIT_CYC + 1);

  typedef enum logic [0:0] {
    S_INIT,
    S_RUN
  } state_t;

  function automatic logic is_fwd(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: is_fwd = 1'b1;
      default:                            is_fwd = 1'b0;
    endcase
  endfunction

  function automatic logic is_rev(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0100, 4'b1101, 4'b1011, 4'b0010: is_rev = 1'b1;
      default:                            is_rev = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [1:0] p, input logic [1:0] c);
    is_illegal = ((p ^ c) == 2'b11);
  endfunction

  // Reset: asserted asynchronously, released on a clock edge
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_i;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_i = rst_sync_q[1];

  // Synchroniser chain, channel index 1 = A, 0 = B
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][SYNC_STAGES-1:0] sync_d;
  logic [1:0]                  synced;

  assign raw = {bus.a_in, bus.b_in};

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      synced[ch] = sync_q[ch][SYNC_STAGES-1];
    end
  end

  // Filter: a new level is accepted only after FILT_LEN consecutive mismatching cycles
  logic [1:0][CNT_W-1:0] fcnt_q;
  logic [1:0][CNT_W-1:0] fcnt_d;
  logic [1:0]            filt_q;
  logic [1:0]            filt_d;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      filt_d[ch] = filt_q[ch];
      fcnt_d[ch] = '0;
      if (synced[ch] != filt_q[ch]) begin
        if (fcnt_q[ch] == CNT_W'(FILT_LEN - 1)) begin
          filt_d[ch] = synced[ch];
        end else begin
          fcnt_d[ch] = fcnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Decode FSM: INIT lets the front end settle before any step is believed
  state_t              state_q;
  state_t              state_d;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [INIT_W-1:0]   init_cnt_d;
  logic [1:0]          prev_q;
  logic [1:0]          prev_d;
  logic                inc_q;
  logic                inc_d;
  logic                dec_q;
  logic                dec_d;
  logic                err_q;
  logic                err_d;
  logic                sticky_q;
  logic                sticky_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = filt_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    err_d      = 1'b0;
    sticky_d   = bus.clr_err ? 1'b0 : sticky_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYC - 1)) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_RUN: begin
        // prev always follows cur, so disabled motion never surfaces on re-enable
        if (bus.en) begin
          if (is_illegal(prev_q, filt_q)) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end else if (MODE == 0) begin
            inc_d = is_fwd(prev_q, filt_q);
            dec_d = is_rev(prev_q, filt_q);
          end else begin
            inc_d = (prev_q == 2'b10) && (filt_q == 2'b00);
            dec_d = (prev_q == 2'b00) && (filt_q == 2'b10);
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      fcnt_q     <= '0;
      filt_q     <= '0;
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      prev_q     <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      fcnt_q     <= fcnt_d;
      filt_q     <= filt_d;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.inc        = inc_q;
  assign bus.dec        = dec_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

  a_one_pulse: assert property (@(posedge clk) disable iff (!rst_n_i)
    $onehot0({inc_q, dec_q, err_q}));

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: an x4 and an x1 instance share one
// stimulus stream; pulses are counted and time-stamped on the falling edge.
module tb_quad_step_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  quad_step_decoder_if if0 ();
  quad_step_decoder_if if1 ();

  assign if1.en      = if0.en;
  assign if1.a_in    = if0.a_in;
  assign if1.b_in    = if0.b_in;
  assign if1.clr_err = if0.clr_err;

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .MODE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .MODE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_inc0 = 0, n_dec0 = 0, n_err0 = 0;
  int n_inc1 = 0, n_dec1 = 0, n_err1 = 0;
  int t_inc0 = 0, t_dec0 = 0, t_err0 = 0;
  int n_wide = 0, n_multi = 0;
  logic p_inc0 = 1'b0, p_dec0 = 1'b0, p_err0 = 1'b0;

  always @(negedge clk) begin
    if (if0.inc === 1'b1) begin n_inc0 <= n_inc0 + 1; t_inc0 <= cyc; end
    if (if0.dec === 1'b1) begin n_dec0 <= n_dec0 + 1; t_dec0 <= cyc; end
    if (if0.err === 1'b1) begin n_err0 <= n_err0 + 1; t_err0 <= cyc; end
    if (if1.inc === 1'b1) n_inc1 <= n_inc1 + 1;
    if (if1.dec === 1'b1) n_dec1 <= n_dec1 + 1;
    if (if1.err === 1'b1) n_err1 <= n_err1 + 1;
    if ((if0.inc === 1'b1 && p_inc0) || (if0.dec === 1'b1 && p_dec0) ||
        (if0.err === 1'b1 && p_err0))
      n_wide <= n_wide + 1;
    if ($countones({if0.inc, if0.dec, if0.err}) > 1 ||
        $countones({if1.inc, if1.dec, if1.err}) > 1)
      n_multi <= n_multi + 1;
    p_inc0 <= (if0.inc === 1'b1);
    p_dec0 <= (if0.dec === 1'b1);
    p_err0 <= (if0.err === 1'b1);
  end

  int b_inc0, b_dec0, b_err0, b_inc1, b_dec1, b_err1;

  task automatic snap();
    b_inc0 = n_inc0; b_dec0 = n_dec0; b_err0 = n_err0;
    b_inc1 = n_inc1; b_dec1 = n_dec1; b_err1 = n_err1;
  endtask

  task automatic step(input logic a, input logic b, output int t0);
    @(negedge clk);
    if0.a_in = a;
    if0.b_in = b;
    t0 = cyc;
    repeat (20) @(negedge clk);
    #1;
  endtask

  logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  initial begin
    int t0;
    if0.en      = 1'b1;
    if0.a_in    = 1'b1;
    if0.b_in    = 1'b1;
    if0.clr_err = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inc", if0.inc, 0);
    chk("rst_dec", if0.dec, 0);
    chk("rst_err", if0.err, 0);
    chk("rst_sticky", if0.err_sticky, 0);

    // Release with encoder parked at 11: INIT must swallow it
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("init11_inc", n_inc0, 0);
    chk("init11_dec", n_dec0, 0);
    chk("init11_err", n_err0 + n_err1, 0);
    chk("init11_sticky", if0.err_sticky, 0);

    // Walk 11 -> 10 -> 00 forward to reach the start of the sequences
    step(1'b1, 1'b0, t0);
    step(1'b0, 1'b0, t0);
    chk("prep_inc_x4", n_inc0, 2);
    chk("prep_inc_x1", n_inc1, 1);

    snap();
    for (int i = 0; i < 4; i++) begin
      step(fwd_seq[i][1], fwd_seq[i][0], t0);
      chk("fwd_latency", t_inc0 - t0, 7);
    end
    chk("fwd_inc_x4", n_inc0 - b_inc0, 4);
    chk("fwd_dec_x4", n_dec0 - b_dec0, 0);
    chk("fwd_inc_x1", n_inc1 - b_inc1, 1);
    chk("fwd_dec_x1", n_dec1 - b_dec1, 0);

    snap();
    for (int i = 0; i < 4; i++) begin
      step(rev_seq[i][1], rev_seq[i][0], t0);
      chk("rev_latency", t_dec0 - t0, 7);
    end
    chk("rev_dec_x4", n_dec0 - b_dec0, 4);
    chk("rev_inc_x4", n_inc0 - b_inc0, 0);
    chk("rev_dec_x1", n_dec1 - b_dec1, 1);
    chk("rev_inc_x1", n_inc1 - b_inc1, 0);

    // Park B high so an A pulse is 01 -> 11 (fwd) -> 01 (rev)
    step(1'b0, 1'b1, t0);
    snap();
    @(negedge clk);
    if0.a_in = 1'b1;
    repeat (3) @(negedge clk);
    if0.a_in = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("glitch_inc", n_inc0 - b_inc0, 0);
    chk("glitch_dec", n_dec0 - b_dec0, 0);

    @(negedge clk);
    if0.a_in = 1'b1;
    repeat (5) @(negedge clk);
    if0.a_in = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk("pulse_inc", n_inc0 - b_inc0, 1);
    chk("pulse_dec", n_dec0 - b_dec0, 1);
    chk("pulse_order", (t_dec0 > t_inc0), 1);
    chk("pulse_x1", (n_inc1 - b_inc1) + (n_dec1 - b_dec1), 0);
    step(1'b0, 1'b0, t0);

    // Illegal jump 00 -> 11
    snap();
    step(1'b1, 1'b1, t0);
    chk("illegal_err", n_err0 - b_err0, 1);
    chk("illegal_latency", t_err0 - t0, 7);
    chk("illegal_incdec", (n_inc0 - b_inc0) + (n_dec0 - b_dec0), 0);
    chk("illegal_sticky", if0.err_sticky, 1);
    chk("illegal_err_x1", n_err1 - b_err1, 1);
    @(negedge clk);
    if0.clr_err = 1'b1;
    @(negedge clk);
    if0.clr_err = 1'b0;
    #1;
    chk("clr_sticky", if0.err_sticky, 0);

    // clr_err lands on the same edge that registers err: set must win
    @(negedge clk);
    if0.a_in = 1'b0;
    if0.b_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("setwins_pre_err", if0.err, 0);
    if0.clr_err = 1'b1;
    @(negedge clk);
    chk("setwins_err", if0.err, 1);
    chk("setwins_sticky", if0.err_sticky, 1);
    if0.clr_err = 1'b0;
    repeat (20) @(negedge clk);
    #1;

    // Motion while disabled must never surface
    snap();
    @(negedge clk);
    if0.en = 1'b0;
    step(1'b0, 1'b1, t0);
    step(1'b1, 1'b1, t0);
    step(1'b1, 1'b0, t0);
    @(negedge clk);
    if0.en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("dis_x4", (n_inc0 - b_inc0) + (n_dec0 - b_dec0) + (n_err0 - b_err0), 0);
    chk("dis_x1", (n_inc1 - b_inc1) + (n_dec1 - b_dec1), 0);
    chk("dis_sticky_held", if0.err_sticky, 1);

    snap();
    step(1'b0, 1'b0, t0);
    chk("reen_inc_x4", n_inc0 - b_inc0, 1);
    chk("reen_dec_x4", n_dec0 - b_dec0, 0);
    chk("reen_inc_x1", n_inc1 - b_inc1, 1);

    // Reset while a pulse is on the output
    @(negedge clk);
    if0.a_in = 1'b0;
    if0.b_in = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_inc_pre", if0.inc, 1);
    chk("mid_sticky_pre", if0.err_sticky, 1);
    #2;
    rst_n = 1'b0;
    if0.a_in = 1'b1;
    if0.b_in = 1'b1;
    #1;
    chk("mid_rst_inc", if0.inc, 0);
    chk("mid_rst_sticky", if0.err_sticky, 0);
    repeat (2) @(negedge clk);
    snap();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("rerel_x4", (n_inc0 - b_inc0) + (n_dec0 - b_dec0) + (n_err0 - b_err0), 0);
    chk("rerel_x1", (n_inc1 - b_inc1) + (n_dec1 - b_dec1) + (n_err1 - b_err1), 0);
    chk("rerel_sticky", if0.err_sticky, 0);

    snap();
    step(1'b1, 1'b0, t0);
    chk("rerun_inc", n_inc0 - b_inc0, 1);
    chk("rerun_latency", t_inc0 - t0, 7);

    chk("pulse_width", n_wide, 0);
    chk("one_pulse", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
